// File: rtl/uart_tx_frame_phy.sv
// rtl/uart_tx_frame_phy.sv - parametrised UART frame transmitter
module uart_tx_frame_phy #(
    parameter int BAUD_DIV    = 434,
    parameter int BYTE_NUM    = 8,
    parameter int PARITY_MODE = 1,
    parameter int STOP_BITS   = 1,
    parameter int GAP_BITS    = 0
) (
    input  logic                    sys_clk,
    input  logic                    reset_n,
    input  logic [BYTE_NUM*8-1:0]   wr_data_in,
    input  logic                    wr_data_valid_in,
    output logic                    wr_data_ready_out,
    output logic                    tx_busy_out,
    output logic                    tx_done_out,
    output logic                    uart_tx_out
);

    localparam int TW = $clog2(BAUD_DIV);
    localparam int BW = (BYTE_NUM > 1) ? $clog2(BYTE_NUM) : 1;
    localparam int DW = BYTE_NUM * 8;
    localparam logic [TW-1:0] TIMER_MAX = TW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(BYTE_NUM - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [3:0]    GAP_LAST  = 4'(GAP_BITS - 1);

    if (BAUD_DIV < 2) begin : g_bad_baud
        $error("BAUD_DIV must be >= 2");
    end
    if (BYTE_NUM < 1 || BYTE_NUM > 16) begin : g_bad_bytes
        $error("BYTE_NUM must be 1..16");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
        $error("PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("STOP_BITS must be 1 or 2");
    end
    if (GAP_BITS < 0 || GAP_BITS > 15) begin : g_bad_gap
        $error("GAP_BITS must be 0..15");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP} state_t;

    state_t          r_state;
    logic [TW-1:0]   r_timer;
    logic [2:0]      r_bit_idx;
    logic [BW-1:0]   r_byte_idx;
    logic [3:0]      r_cnt;
    logic [DW-1:0]   r_buf;
    logic [7:0]      r_byte;
    logic            w_bit_end;
    logic            w_par;

    assign w_bit_end = (r_timer == TIMER_MAX);
    assign w_par     = (PARITY_MODE == 2) ? ~(^r_byte) : (^r_byte);

    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            r_state           <= IDLE;
            r_timer           <= '0;
            r_bit_idx         <= '0;
            r_byte_idx        <= '0;
            r_cnt             <= '0;
            r_buf             <= '0;
            r_byte            <= '0;
            uart_tx_out       <= 1'b1;
            wr_data_ready_out <= 1'b0;
            tx_busy_out       <= 1'b0;
            tx_done_out       <= 1'b0;
        end else begin
            tx_done_out <= 1'b0;
            if (r_state != IDLE) begin
                r_timer <= w_bit_end ? '0 : r_timer + TW'(1);
            end
            case (r_state)
                IDLE: begin
                    uart_tx_out <= 1'b1;
                    tx_busy_out <= 1'b0;
                    if (wr_data_ready_out && wr_data_valid_in) begin
                        // First byte goes straight to r_byte; the rest wait in r_buf.
                        r_byte            <= wr_data_in[DW-1 -: 8];
                        r_buf             <= wr_data_in << 8;
                        r_byte_idx        <= '0;
                        r_timer           <= '0;
                        uart_tx_out       <= 1'b0;
                        wr_data_ready_out <= 1'b0;
                        tx_busy_out       <= 1'b1;
                        r_state           <= START;
                    end else begin
                        wr_data_ready_out <= 1'b1;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_bit_idx   <= '0;
                        uart_tx_out <= r_byte[0];
                        r_state     <= DATA;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == 3'd7) begin
                            r_cnt <= '0;
                            if (PARITY_MODE != 0) begin
                                uart_tx_out <= w_par;
                                r_state     <= PARITY;
                            end else begin
                                uart_tx_out <= 1'b1;
                                r_state     <= STOP;
                            end
                        end else begin
                            r_bit_idx   <= r_bit_idx + 3'd1;
                            uart_tx_out <= r_byte[r_bit_idx + 3'd1];
                        end
                    end
                end
                PARITY: begin
                    if (w_bit_end) begin
                        uart_tx_out <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= STOP;
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        if (r_cnt != STOP_LAST) begin
                            r_cnt <= r_cnt + 4'd1;
                        end else if (r_byte_idx == LAST_BYTE) begin
                            tx_done_out       <= 1'b1;
                            tx_busy_out       <= 1'b0;
                            wr_data_ready_out <= 1'b1;
                            r_state           <= IDLE;
                        end else if (GAP_BITS > 0) begin
                            r_cnt   <= '0;
                            r_state <= GAP;
                        end else begin
                            r_byte      <= r_buf[DW-1 -: 8];
                            r_buf       <= r_buf << 8;
                            r_byte_idx  <= r_byte_idx + BW'(1);
                            uart_tx_out <= 1'b0;
                            r_state     <= START;
                        end
                    end
                end
                GAP: begin
                    if (w_bit_end) begin
                        if (r_cnt != GAP_LAST) begin
                            r_cnt <= r_cnt + 4'd1;
                        end else begin
                            r_byte      <= r_buf[DW-1 -: 8];
                            r_buf       <= r_buf << 8;
                            r_byte_idx  <= r_byte_idx + BW'(1);
                            uart_tx_out <= 1'b0;
                            r_state     <= START;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_tx_frame_phy.md
# uart_tx_frame_phy

Parametrised UART frame transmitter: accepts a word of BYTE_NUM bytes in one valid/ready handshake and serialises it byte by byte on a single TX line. Baud divisor, parity mode, stop-bit count and inter-byte gap are configurable. It adds busy and done status outputs. It sits between the host-telemetry packer and the board UART pin, and replaces the fixed 8-byte, even-parity, 230400 transmitter.

## Interface
- BAUD_DIV, 434: sys_clk cycles per UART bit; legal range ≥ 2.
- BYTE_NUM, 8: bytes per accepted word; legal range 1..16.
- PARITY_MODE, 1: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: stop bits per byte; legal values 1 or 2.
- GAP_BITS, 0: idle-high bit times inserted between bytes, not after the last byte; legal range 0..15.

- sys_clk  in  1  system clock.
- reset_n  in  1  reset; synchronous, active-low.
- wr_data_in  in  BYTE_NUM*8  payload. Byte [BYTE_NUM*8-1 -: 8] is sent first. Each byte is sent LSB first.
- wr_data_valid_in  in  1  payload valid.
- wr_data_ready_out  out  1  ready to accept a payload.
- tx_busy_out  out  1  frame in progress.
- tx_done_out  out  1  one-cycle pulse when the frame completes.
- uart_tx_out  out  1  serial line; idle level is high.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP, GAP.
- Bit timer counts 0..BAUD_DIV-1. A bit ends when the timer reaches BAUD_DIV-1. Timer and bit counters are $clog2-sized.
- IDLE:
  - wr_data_ready_out = 1.
  - Acceptance occurs on a clock edge where valid and ready are both 1.
  - At acceptance, the whole payload is captured into a shift buffer and the byte index is cleared. The FSM then moves to START.
- START: line driven 0 for one bit time, then → DATA.
- DATA: sends 8 bits, LSB first. After bit 7: → PARITY if PARITY_MODE ≠ 0, otherwise → STOP.
- PARITY: one bit time.
  - Even mode: parity bit = XOR of the 8 data bits.
  - Odd mode: parity bit = the inverse of that XOR.
- STOP: line high for STOP_BITS bit times. At the end of the stop bits:
  - Last byte: → IDLE.
  - Otherwise, if GAP_BITS > 0: → GAP.
  - Otherwise: → START with the next byte.
- GAP: line high for GAP_BITS bit times, then → START.
- Input isolation: changes on wr_data_in after acceptance have no effect. Valid asserted while busy is ignored and is never queued.
- Counters do not wrap mid-frame. The byte index runs 0..BYTE_NUM-1 and the data bit index runs 0..7.
- Illegal parameter values are a $error at elaboration time.

## Timing
- Reset values, with reset_n low at a clock edge:
  - uart_tx_out = 1
  - wr_data_ready_out = 0
  - tx_busy_out = 0
  - tx_done_out = 0
  - FSM = IDLE
- wr_data_ready_out goes to 1 at the first edge after reset_n is sampled high.
- All outputs are registered.
- Acceptance at edge k:
  - From edge k: uart_tx_out = 0 (start bit), ready = 0, busy = 1.
  - Each bit lasts exactly BAUD_DIV cycles.
- Bits per byte: B = 9 + (PARITY_MODE≠0) + STOP_BITS.
- Frame length: N = BAUD_DIV × (BYTE_NUM×B + (BYTE_NUM−1)×GAP_BITS) cycles.
- At edge k+N:
  - tx_done_out = 1 for one cycle.
  - busy = 0.
  - ready = 1.
  - Line stays high.
- Back-to-back frames with valid held high: the next acceptance occurs at edge k+N+1. The minimum idle between frames is therefore 1 cycle.
- Reset mid-frame: at the next edge all outputs return to their reset values. The frame is discarded, and no done pulse is produced.

## Test plan
Unless stated otherwise, tests use BAUD_DIV=4, BYTE_NUM=2, PARITY_MODE=1, STOP_BITS=1, GAP_BITS=0.

1. Reset behaviour: hold reset_n low for 5 cycles with valid=1 → tx=1, ready=0, busy=0, done=0 throughout. Ready=1 one cycle after release.
2. Even parity: send 16'hA501 →
   - Line bits, 4 cycles each: 0,1,0,1,0,0,1,0,1,0,1 then 0,1,0,0,0,0,0,0,0,1,1.
   - Done pulse and ready at 88 cycles after acceptance.
3. Odd parity, 2 stop bits, gap: PARITY_MODE=2, STOP_BITS=2, GAP_BITS=1; send 16'hFF00 →
   - Parity bit 1 for both bytes.
   - 4 high cycles of gap between bytes.
   - Done at 100 cycles.
4. No parity, input isolation: PARITY_MODE=0; send 16'h3C00, then change data to 16'hFFFF and pulse valid mid-frame →
   - Line carries 3C,00 with 10-bit bytes.
   - Done at 80 cycles.
   - Exactly one done pulse; the second valid is ignored.
5. Back-to-back: hold valid=1 with 16'h1234 →
   - Second start bit begins 1 cycle after the first done pulse.
   - Two done pulses, 89 cycles apart.
6. Reset mid-frame: assert reset_n low during the DATA state of byte 0 → next edge tx=1, busy=0, done=0. A new frame after release is transmitted correctly.
